// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: arbitrates ID/EXE branch-taken requests into a
// two-cycle redirect/squash sequence and keeps saturating redirect statistics.
module branch_redirect_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       pcsrc1,
  input  logic       pcsrc2,
  input  logic [5:0] id_bra_pc,
  input  logic [5:0] exe_bra_pc,
  input  logic       stall_in,
  input  logic       clr_cnt,
  output logic       pc_load,
  output logic [5:0] next_pc,
  output logic       flush_ifid,
  output logic       flush_idexe,
  output logic       busy,
  output logic [7:0] taken_cnt,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDIR  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t     r_state;
  logic [5:0] r_target;
  logic       r_src_exe;
  logic       r_pc_load;
  logic       r_flush_ifid;
  logic       r_flush_idexe;
  logic       r_busy;
  logic [7:0] r_taken_cnt;
  logic [7:0] r_drop_cnt;

  logic w_idle;
  logic w_acc_exe;
  logic w_acc_id;
  logic w_accept;
  logic w_conflict;

  // Requests are only looked at in IDLE; anything seen mid-sequence is wrong-path.
  // An ID request is unusable while a load-use stall leaves its operands invalid.
  assign w_idle     = (r_state == IDLE);
  assign w_acc_exe  = w_idle & pcsrc2;
  assign w_acc_id   = w_idle & ~pcsrc2 & pcsrc1 & ~stall_in;
  assign w_accept   = w_acc_exe | w_acc_id;
  assign w_conflict = w_idle & pcsrc1 & pcsrc2;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_target      <= 6'd0;
      r_src_exe     <= 1'b0;
      r_pc_load     <= 1'b0;
      r_flush_ifid  <= 1'b0;
      r_flush_idexe <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state       <= REDIR;
            r_target      <= w_acc_exe ? exe_bra_pc : id_bra_pc;
            r_src_exe     <= w_acc_exe;
            r_pc_load     <= 1'b1;
            r_flush_ifid  <= 1'b1;
            r_flush_idexe <= w_acc_exe;
            r_busy        <= 1'b1;
          end
        end
        REDIR: begin
          r_state       <= SQUASH;
          r_pc_load     <= 1'b0;
          r_flush_ifid  <= 1'b1;
          r_flush_idexe <= 1'b0;
          r_busy        <= 1'b1;
        end
        default: begin
          r_state       <= IDLE;
          r_pc_load     <= 1'b0;
          r_flush_ifid  <= 1'b0;
          r_flush_idexe <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  // Statistics: clear beats a coincident increment; both hold at 255.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_taken_cnt <= 8'd0;
      r_drop_cnt  <= 8'd0;
    end else begin
      if (w_accept && (r_taken_cnt != 8'hFF))
        r_taken_cnt <= r_taken_cnt + 8'd1;
      if (w_conflict && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign pc_load     = r_pc_load;
  assign next_pc     = r_target;
  assign flush_ifid  = r_flush_ifid;
  assign flush_idexe = r_flush_idexe;
  assign busy        = r_busy;
  assign taken_cnt   = r_taken_cnt;
  assign drop_cnt    = r_drop_cnt;

  // r_src_exe is kept as the recorded winner of the last acceptance.
  logic w_unused;
  assign w_unused = r_src_exe;

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 pcsrc1  in  1  ID-stage equal-branch taken request.
REQ-005 pcsrc2  in  1  EXE-stage gt/le-branch taken request.
REQ-006 id_bra_pc  in  6  ID-stage branch target.
REQ-007 exe_bra_pc  in  6  EXE-stage branch target.
REQ-008 stall_in  in  1  load-use hazard stall active; ID operands invalid.
REQ-009 clr_cnt  in  1  synchronous clear of statistics counters.
REQ-010 pc_load  out  1  PC loads next_pc this cycle.
REQ-011 next_pc  out  6  redirect target, registered.
REQ-012 flush_ifid  out  1  squash IF/ID register contents.
REQ-013 flush_idexe  out  1  squash ID/EXE register contents.
REQ-014 busy  out  1  redirect sequence in progress.
REQ-015 taken_cnt  out  8  accepted redirects, saturating.
REQ-016 drop_cnt  out  8  ID requests discarded by EXE priority, saturating.

Function
REQ-017 SHALL implement FSM with states IDLE, REDIR, SQUASH; each non-IDLE state lasts exactly 1 cycle.
REQ-018 IDLE, pcsrc2=1 -> REDIR; target_q<=exe_bra_pc; src_exe<=1.
REQ-019 IDLE, pcsrc2=0, pcsrc1=1, stall_in=0 -> REDIR; target_q<=id_bra_pc; src_exe<=0.
REQ-020 IDLE, pcsrc1=1 with stall_in=1 and pcsrc2=0 SHALL be ignored (no transition, no count).
REQ-021 pcsrc2 SHALL be accepted in IDLE regardless of stall_in.
REQ-022 pcsrc1=1 and pcsrc2=1 same IDLE cycle: EXE wins; drop_cnt increments by 1 (saturating), even when stall_in=1.
REQ-023 REDIR: pc_load=1, next_pc=target_q, flush_ifid=1, flush_idexe=src_exe; -> SQUASH.
REQ-024 SQUASH: pc_load=0, flush_ifid=1, flush_idexe=0; -> IDLE.
REQ-025 IDLE: pc_load=0, flush_ifid=0, flush_idexe=0.
REQ-026 pcsrc1/pcsrc2 in REDIR and SQUASH SHALL be ignored (wrong-path); not counted in either counter.
REQ-027 next_pc SHALL hold target_q in all states; target_q changes only on IDLE acceptance.
REQ-028 busy = 1 in REDIR and SQUASH, else 0; registered-state decode, no input dependence.
REQ-029 All outputs SHALL be decodes of registered state only (no combinational input-to-output path).
REQ-030 Latency: request accepted at edge ending cycle T -> pc_load=1 in cycle T+1 -> next acceptance possible earliest in cycle T+3.
REQ-031 taken_cnt increments by 1 on each IDLE->REDIR transition; holds at 255.
REQ-032 clr_cnt=1 SHALL zero both counters next edge; if an increment coincides, clear wins.
REQ-033 Back-to-back: request held high through a sequence SHALL produce a new REDIR in cycle T+3, not earlier.

Reset
REQ-034 rst=1 at edge: state<=IDLE, target_q<=0, src_exe<=0, taken_cnt<=0, drop_cnt<=0.
REQ-035 After reset: pc_load=0, next_pc=0, flush_ifid=0, flush_idexe=0, busy=0.
REQ-036 rst SHALL override all inputs including clr_cnt and pending requests.
REQ-037 rst asserted during REDIR or SQUASH SHALL abort sequence; next cycle IDLE, no further pc_load/flush.

Verification
REQ-038 pcsrc1=1, id_bra_pc=6'h15, stall_in=0 for one cycle -> next cycle pc_load=1, next_pc=6'h15, flush_ifid=1, flush_idexe=0; following cycle flush_ifid=1 only; taken_cnt=1.
REQ-039 pcsrc1=1 (id=6'h0A) and pcsrc2=1 (exe=6'h33) same cycle -> REDIR with next_pc=6'h33, flush_idexe=1; taken_cnt=1, drop_cnt=1.
REQ-040 pcsrc1=1 with stall_in=1 -> no pc_load, busy stays 0, counters unchanged; then stall_in=0 -> accepted next edge.
REQ-041 pcsrc2 held high 10 cycles, exe_bra_pc=6'h3F -> pc_load pulses every 3rd cycle (cycles 1,4,7), taken_cnt=4 after cycle 10 edge.
REQ-042 rst=1 during REDIR -> next cycle all outputs 0, state IDLE; 256 accepted redirects then one more -> taken_cnt=255; clr_cnt=1 -> 0.
